// File: rtl/life_pkg.sv
// Shared types, rule constants and indexing helper for the Game-of-Life engine.
package life_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} life_state_t;

    localparam int unsigned BIRTH_COUNT = 3;
    localparam int unsigned SURVIVE_MIN = 2;
    localparam int unsigned SURVIVE_MAX = 3;

    function automatic int unsigned cell_index(input int unsigned r, input int unsigned c,
                                               input int unsigned cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/life_next_grid.sv
// Combinational next-generation evaluator; LIFE_TORUS_EN selects wrapped edges,
// otherwise cells beyond the grid read as dead.
module life_next_grid
    import life_pkg::*;
#(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8
) (
    input  logic [ROWS*COLS-1:0] cells,
    output logic [ROWS*COLS-1:0] next_cells_c,
    output logic                 same_flag_c
);

    localparam int unsigned N     = ROWS * COLS;
    localparam int unsigned IDX_W = $clog2(N);

    logic [3:0] nbr_cnt;
    int         nr;
    int         nc;

    always_comb begin
        next_cells_c = '0;
        nbr_cnt      = '0;
        nr           = 0;
        nc           = 0;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                nbr_cnt = '0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
`ifdef LIFE_TORUS_EN
                            nr = (r + dr + int'(ROWS)) % int'(ROWS);
                            nc = (c + dc + int'(COLS)) % int'(COLS);
                            nbr_cnt = nbr_cnt + 4'(cells[IDX_W'(cell_index(nr, nc, COLS))]);
`else
                            nr = r + dr;
                            nc = c + dc;
                            if (nr >= 0 && nr < int'(ROWS) && nc >= 0 && nc < int'(COLS))
                                nbr_cnt = nbr_cnt + 4'(cells[IDX_W'(cell_index(nr, nc, COLS))]);
`endif
                        end
                    end
                end
                next_cells_c[IDX_W'(cell_index(r, c, COLS))] =
                    (nbr_cnt == 4'(BIRTH_COUNT)) ||
                    (cells[IDX_W'(cell_index(r, c, COLS))] &&
                     nbr_cnt >= 4'(SURVIVE_MIN) && nbr_cnt <= 4'(SURVIVE_MAX));
            end
        end
    end

    assign same_flag_c = (next_cells_c == cells);

endmodule

// File: rtl/life_engine.sv
// Game-of-Life engine: run/pause/step FSM, tick divider, generation counter, still-life halt.
// Build with LIFE_TORUS_EN defined for wrapped (toroidal) grid edges.
module life_engine
    import life_pkg::*;
#(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned COLS     = 8,
    parameter int unsigned TICK_DIV = 23,
    parameter int unsigned GEN_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] init_cells,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 step,
    output logic [ROWS*COLS-1:0] cells,
    output logic [GEN_W-1:0]     generation,
    output logic                 running,
    output logic                 halted,
    output logic                 extinct,
    output logic                 updated
);

    localparam int unsigned N = ROWS * COLS;

    life_state_t           state_q, state_d;
    logic [TICK_DIV-1:0]   tick_q, tick_d;
    logic [N-1:0]          cells_d;
    logic [GEN_W-1:0]      gen_d;
    logic                  updated_d;
    logic [N-1:0]          next_cells_c;
    logic                  same_flag_c;
    logic                  do_gen_c;

    life_next_grid #(.ROWS(ROWS), .COLS(COLS)) u_next (
        .cells        (cells),
        .next_cells_c (next_cells_c),
        .same_flag_c  (same_flag_c)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            cells      <= '0;
            generation <= '0;
            running    <= 1'b0;
            halted     <= 1'b0;
            extinct    <= 1'b1;
            updated    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            cells      <= cells_d;
            generation <= gen_d;
            running    <= (state_d == S_RUN);
            halted     <= (state_d == S_HALT);
            extinct    <= (cells_d == '0);
            updated    <= updated_d;
        end
    end

    // Next-state logic; priority load > stop > start > step, tick only when no override
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        cells_d   = cells;
        gen_d     = generation;
        updated_d = 1'b0;
        do_gen_c  = 1'b0;
        if (load) begin
            cells_d = init_cells;
            gen_d   = '0;
            tick_d  = '0;
            state_d = S_IDLE;
        end else if (stop) begin
            if (state_q == S_RUN) state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        tick_d  = '0;
                    end else if (step) begin
                        do_gen_c = 1'b1;
                    end
                end
                S_RUN: begin
                    tick_d = tick_q + 1'b1;
                    if (tick_q == '1) begin
                        if (same_flag_c) state_d  = S_HALT;
                        else             do_gen_c = 1'b1;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        state_d = S_RUN;
                        tick_d  = '0;
                    end else if (step) begin
                        state_d  = S_IDLE;
                        do_gen_c = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (do_gen_c) begin
            cells_d   = next_cells_c;
            gen_d     = generation + 1'b1;
            updated_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: 5x5 and 8x8 instances, TICK_DIV=2 (tick every 4 clocks).
module tb_life_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 5x5 instance
    logic        s_load, s_start, s_stop, s_step;
    logic [24:0] s_init, s_cells;
    logic [15:0] s_gen;
    logic        s_running, s_halted, s_extinct, s_updated;

    // 8x8 instance
    logic        b_load, b_start, b_stop, b_step;
    logic [63:0] b_init, b_cells;
    logic [15:0] b_gen;
    logic        b_running, b_halted, b_extinct, b_updated;

    life_engine #(.ROWS(5), .COLS(5), .TICK_DIV(2), .GEN_W(16)) u_small (
        .clk(clk), .rst_n(rst_n), .load(s_load), .init_cells(s_init),
        .start(s_start), .stop(s_stop), .step(s_step), .cells(s_cells),
        .generation(s_gen), .running(s_running), .halted(s_halted),
        .extinct(s_extinct), .updated(s_updated)
    );

    life_engine #(.ROWS(8), .COLS(8), .TICK_DIV(2), .GEN_W(16)) u_big (
        .clk(clk), .rst_n(rst_n), .load(b_load), .init_cells(b_init),
        .start(b_start), .stop(b_stop), .step(b_step), .cells(b_cells),
        .generation(b_gen), .running(b_running), .halted(b_halted),
        .extinct(b_extinct), .updated(b_updated)
    );

    localparam logic [24:0] BLINK_H = 25'h0003800;  // cells 11,12,13
    localparam logic [24:0] BLINK_V = 25'h0021080;  // cells 7,12,17
    localparam logic [24:0] BLOCK5  = 25'h00018C0;  // cells 6,7,11,12
    localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;  // cells 1,10,16,17,18
    localparam logic [63:0] GLIDER4 = 64'h0000_0000_0E08_0400;  // glider shifted (+1,+1)
    localparam logic [63:0] BLOCK8  = 64'hC0C0_0000_0000_0000;  // cells 54,55,62,63

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic s_pulse_load(input logic [24:0] pat);
        s_init = pat; s_load = 1'b1; cyc(1); s_load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        {s_load, s_start, s_stop, s_step} = '0;
        {b_load, b_start, b_stop, b_step} = '0;
        s_init = '0;
        b_init = '0;
        cyc(1);
        check("rst_cells",   64'(s_cells),   64'h0);
        check("rst_gen",     64'(s_gen),     64'h0);
        check("rst_extinct", 64'(s_extinct), 64'h1);
        check("rst_running", 64'(s_running), 64'h0);
        check("rst_halted",  64'(s_halted),  64'h0);
        check("rst_updated", 64'(s_updated), 64'h0);
        check("rst_bcells",  b_cells,        64'h0);
        rst_n = 1'b1;
        cyc(1);

        // Blinker, single step while idle
        s_pulse_load(BLINK_H);
        check("blk_load_cells", 64'(s_cells),   64'(BLINK_H));
        check("blk_load_gen",   64'(s_gen),     64'h0);
        check("blk_load_ext",   64'(s_extinct), 64'h0);
        check("blk_load_upd",   64'(s_updated), 64'h0);
        s_step = 1'b1; cyc(1); s_step = 1'b0;
        check("blk_step_cells", 64'(s_cells),   64'(BLINK_V));
        check("blk_step_gen",   64'(s_gen),     64'h1);
        check("blk_step_upd",   64'(s_updated), 64'h1);
        cyc(1);
        check("blk_upd_drop",   64'(s_updated), 64'h0);
        check("blk_idle_cells", 64'(s_cells),   64'(BLINK_V));

        // Still-life block halts on first tick
        s_pulse_load(BLOCK5);
        s_start = 1'b1; cyc(1); s_start = 1'b0;
        cyc(3);
        check("blkst_running",  64'(s_running), 64'h1);
        check("blkst_gen0",     64'(s_gen),     64'h0);
        cyc(1);
        check("blkst_halted",   64'(s_halted),  64'h1);
        check("blkst_notrun",   64'(s_running), 64'h0);
        check("blkst_cells",    64'(s_cells),   64'(BLOCK5));
        check("blkst_gen",      64'(s_gen),     64'h0);
        check("blkst_noupd",    64'(s_updated), 64'h0);
        s_step = 1'b1; cyc(1); s_step = 1'b0;
        check("halt_step_gen",  64'(s_gen),     64'h1);
        check("halt_step_upd",  64'(s_updated), 64'h1);
        check("halt_step_idle", 64'(s_halted),  64'h0);
        check("halt_step_cell", 64'(s_cells),   64'(BLOCK5));

        // Lone cell dies, extinct grid halts on the following tick
        s_pulse_load(25'h0001000);
        check("ext_load", 64'(s_extinct), 64'h0);
        s_start = 1'b1; cyc(1); s_start = 1'b0;
        cyc(4);
        check("ext_gen1",    64'(s_gen),     64'h1);
        check("ext_cells",   64'(s_cells),   64'h0);
        check("ext_flag",    64'(s_extinct), 64'h1);
        check("ext_running", 64'(s_running), 64'h1);
        cyc(4);
        check("ext_halted",  64'(s_halted),  64'h1);
        check("ext_gen_frz", 64'(s_gen),     64'h1);

        // Stop pauses the run
        s_pulse_load(BLINK_H);
        s_start = 1'b1; cyc(1); s_start = 1'b0;
        cyc(2);
        s_stop = 1'b1; cyc(1); s_stop = 1'b0;
        check("stop_running", 64'(s_running), 64'h0);
        cyc(8);
        check("stop_gen", 64'(s_gen), 64'h0);

        // Load beats start mid-run
        s_pulse_load(BLINK_H);
        s_start = 1'b1; cyc(1); s_start = 1'b0;
        cyc(5);
        check("mid_gen1",  64'(s_gen),   64'h1);
        check("mid_cells", 64'(s_cells), 64'(BLINK_V));
        s_init = 25'h000001F; s_load = 1'b1; s_start = 1'b1;
        cyc(1);
        s_load = 1'b0; s_start = 1'b0;
        check("ls_cells",   64'(s_cells),   64'h1F);
        check("ls_gen",     64'(s_gen),     64'h0);
        check("ls_running", 64'(s_running), 64'h0);
        check("ls_halted",  64'(s_halted),  64'h0);
        cyc(8);
        check("ls_idle_gen", 64'(s_gen), 64'h0);

        // Reset mid-run
        s_pulse_load(BLINK_H);
        s_start = 1'b1; cyc(1); s_start = 1'b0;
        cyc(6);
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        check("mrst_cells",   64'(s_cells),   64'h0);
        check("mrst_gen",     64'(s_gen),     64'h0);
        check("mrst_extinct", 64'(s_extinct), 64'h1);
        check("mrst_running", 64'(s_running), 64'h0);
        check("mrst_halted",  64'(s_halted),  64'h0);
        cyc(8);
        check("mrst_idle_gen", 64'(s_gen), 64'h0);

        // 8x8 glider
        b_init = GLIDER; b_load = 1'b1; cyc(1); b_load = 1'b0;
        check("gl_load", b_cells, GLIDER);
        b_start = 1'b1; cyc(1); b_start = 1'b0;
        cyc(16);
        check("gl_gen4",   64'(b_gen), 64'd4);
        check("gl_cells4", b_cells,    GLIDER4);
`ifdef LIFE_TORUS_EN
        cyc(112);
        check("tor_gen32",   64'(b_gen),     64'd32);
        check("tor_cells",   b_cells,        GLIDER);
        check("tor_running", 64'(b_running), 64'h1);
`else
        cyc(76);
        check("edge_gen23",   64'(b_gen),     64'd23);
        check("edge_block",   b_cells,        BLOCK8);
        check("edge_running", 64'(b_running), 64'h1);
        cyc(4);
        check("edge_halted",  64'(b_halted),  64'h1);
        check("edge_gen_frz", 64'(b_gen),     64'd23);
        check("edge_extinct", 64'(b_extinct), 64'h0);
        cyc(8);
        check("edge_gen_hold", 64'(b_gen),    64'd23);
        check("edge_cells",    b_cells,       BLOCK8);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
